// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-code receive path: tracker states,
// error counter ceiling and the modular phase-advance helper.
package johnson_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int ERR_CNT_MAX = 255;

    // Successor of idx in a 2*size-phase Johnson sequence; wraps to 0.
    function automatic int unsigned next_phase(input int unsigned idx, input int unsigned size);
        return (idx + 1) % (2 * size);
    endfunction

endpackage

// File: rtl/johnson_code2idx.sv
// Combinational Johnson decoder: flags whether a code is a legal Johnson word
// and maps it to its binary phase index (ones shift in from the MSB).
module johnson_code2idx #(
    parameter  int SIZE  = 4,
    localparam int IDX_W = $clog2(2 * SIZE)
) (
    input  logic [SIZE-1:0]  code,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    logic [SIZE-2:0] edges;
    int unsigned     ones_cnt;
    int unsigned     trans_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE - 1; gi++) begin : g_edge
            assign edges[gi] = code[gi+1] ^ code[gi];
        end
    endgenerate

    always_comb begin
        ones_cnt  = 0;
        trans_cnt = 0;
        for (int i = 0; i < SIZE; i++) begin
            ones_cnt = ones_cnt + {31'd0, code[i]};
        end
        for (int i = 0; i < SIZE - 1; i++) begin
            trans_cnt = trans_cnt + {31'd0, edges[i]};
        end
    end

    // A legal word has a single run boundary at most. A set MSB means the
    // filling half (phase = number of ones); a clear MSB with any ones means
    // the draining half (phase = 2*SIZE - ones).
    always_comb begin
        legal = (trans_cnt <= 1);
        if (code[SIZE-1]) begin
            idx = IDX_W'(ones_cnt);
        end else if (ones_cnt == 0) begin
            idx = '0;
        end else begin
            idx = IDX_W'(2 * SIZE - ones_cnt);
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// Samples a Johnson-coded word on each qualified cycle, decodes its phase,
// checks legality and single-step advance, and tracks lock to the sequence.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int SIZE   = 4,
    parameter  int LOCK_N = 3,
    localparam int IDX_W  = $clog2(2 * SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SIZE-1:0]  in_code,
    output logic [IDX_W-1:0] phase,
    output logic             phase_valid,
    output logic             locked,
    output logic             code_err,
    output logic             step_err,
    output logic [7:0]       err_count
);

    state_t           state_reg,       state_next;
    logic [IDX_W-1:0] phase_reg,       phase_next;
    logic             phase_valid_reg, phase_valid_next;
    logic             locked_reg,      locked_next;
    logic             code_err_reg,    code_err_next;
    logic             step_err_reg,    step_err_next;
    logic [7:0]       err_count_reg,   err_count_next;
    logic [3:0]       cnt_reg,         cnt_next;

    logic             dec_legal;
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W-1:0] expected_idx;
    logic             is_expected;

    johnson_code2idx #(
        .SIZE (SIZE)
    ) u_code2idx (
        .code  (in_code),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    // The phase register always holds the last legal sample, so it doubles
    // as the reference for the step check.
    assign expected_idx = IDX_W'(next_phase(32'(phase_reg), 32'(SIZE)));
    assign is_expected  = (dec_idx == expected_idx);

    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        phase_valid_next = phase_valid_reg;
        cnt_next         = cnt_reg;
        code_err_next    = 1'b0;
        step_err_next    = 1'b0;

        if (in_valid) begin
            if (!dec_legal) begin
                code_err_next    = 1'b1;
                phase_valid_next = 1'b0;
                state_next       = SEARCH;
                cnt_next         = '0;
            end else begin
                phase_next       = dec_idx;
                phase_valid_next = 1'b1;
                unique case (state_reg)
                    SEARCH: begin
                        state_next = TRACK;
                        cnt_next   = '0;
                    end
                    TRACK: begin
                        if (is_expected) begin
                            cnt_next = cnt_reg + 4'd1;
                            if (cnt_reg == 4'(LOCK_N - 1)) begin
                                state_next = LOCKED;
                            end
                        end else begin
                            step_err_next = 1'b1;
                            cnt_next      = '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_expected) begin
                            step_err_next = 1'b1;
                            state_next    = TRACK;
                            cnt_next      = '0;
                        end
                    end
                    default: begin
                        state_next = SEARCH;
                        cnt_next   = '0;
                    end
                endcase
            end
        end

        locked_next = (state_next == LOCKED);

        err_count_next = err_count_reg;
        if ((code_err_next || step_err_next) && (err_count_reg != 8'(ERR_CNT_MAX))) begin
            err_count_next = err_count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= SEARCH;
            phase_reg       <= '0;
            phase_valid_reg <= 1'b0;
            locked_reg      <= 1'b0;
            code_err_reg    <= 1'b0;
            step_err_reg    <= 1'b0;
            err_count_reg   <= '0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            phase_valid_reg <= phase_valid_next;
            locked_reg      <= locked_next;
            code_err_reg    <= code_err_next;
            step_err_reg    <= step_err_next;
            err_count_reg   <= err_count_next;
            cnt_reg         <= cnt_next;
        end
    end

    assign phase       = phase_reg;
    assign phase_valid = phase_valid_reg;
    assign locked      = locked_reg;
    assign code_err    = code_err_reg;
    assign step_err    = step_err_reg;
    assign err_count   = err_count_reg;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: a phase-table model checked every cycle
// plus hand-computed literal expectations at key points of the sequence.
module tb_johnson_decoder;

    localparam int SZ     = 4;
    localparam int LOCKN  = 3;
    localparam int IW     = $clog2(2 * SZ);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [SZ-1:0] in_code;
    logic [IW-1:0] phase;
    logic          phase_valid;
    logic          locked;
    logic          code_err;
    logic          step_err;
    logic [7:0]    err_count;

    int total = 0;
    int bad   = 0;

    johnson_decoder #(
        .SIZE   (SZ),
        .LOCK_N (LOCKN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_code     (in_code),
        .phase       (phase),
        .phase_valid (phase_valid),
        .locked      (locked),
        .code_err    (code_err),
        .step_err    (step_err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Johnson word for phase p, built from the phase rules directly.
    function automatic logic [SZ-1:0] code_of(input int p);
        logic [SZ-1:0] c;
        c = '0;
        for (int b = 0; b < SZ; b++) begin
            if (p <= SZ) c[SZ-1-b] = (b < p);
            else         c[SZ-1-b] = (b >= p - SZ);
        end
        return c;
    endfunction

    // Phase whose word equals c, or -1 when no phase produces it.
    function automatic int decode(input logic [SZ-1:0] c);
        int r;
        r = -1;
        for (int p = 0; p < 2 * SZ; p++) begin
            if (code_of(p) == c) r = p;
        end
        return r;
    endfunction

    int dec;
    always_comb dec = decode(in_code);

    int m_phase, m_pv, m_have, m_run, m_cerr, m_serr, m_errs;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0; m_pv <= 0; m_have <= 0; m_run <= 0;
            m_cerr <= 0; m_serr <= 0; m_errs <= 0;
        end else if (in_valid) begin
            if (dec < 0) begin
                m_cerr <= 1; m_serr <= 0; m_have <= 0; m_run <= 0; m_pv <= 0;
                m_errs <= (m_errs < 255) ? m_errs + 1 : 255;
            end else begin
                m_phase <= dec; m_pv <= 1; m_have <= 1; m_cerr <= 0;
                if (m_have != 0 && dec == (m_phase + 1) % (2 * SZ)) begin
                    m_serr <= 0;
                    m_run  <= (m_run < 1000) ? m_run + 1 : m_run;
                end else if (m_have != 0) begin
                    m_serr <= 1; m_run <= 0;
                    m_errs <= (m_errs < 255) ? m_errs + 1 : 255;
                end else begin
                    m_serr <= 0; m_run <= 0;
                end
            end
        end else begin
            m_cerr <= 0; m_serr <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_phase",       int'(phase),       m_phase);
        chk("m_phase_valid", int'(phase_valid), m_pv);
        chk("m_locked",      int'(locked),      (m_run >= LOCKN) ? 1 : 0);
        chk("m_code_err",    int'(code_err),    m_cerr);
        chk("m_step_err",    int'(step_err),    m_serr);
        chk("m_err_count",   int'(err_count),   m_errs);
    end

    task automatic send(input logic v, input logic [SZ-1:0] c);
        in_valid = v;
        in_code  = c;
        @(posedge clk);
        #1;
        $display("txn v=%0b code=%b -> phase=%0d pv=%0b lock=%0b cerr=%0b serr=%0b errs=%0d",
                 v, c, phase, phase_valid, locked, code_err, step_err, err_count);
    endtask

    task automatic send_seq(input logic [4*SZ*4-1:0] codes, input int n);
        for (int i = n - 1; i >= 0; i--) send(1'b1, codes[i*SZ +: SZ]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"},  int'(phase),       0);
        chk({tag, "_pv"},     int'(phase_valid), 0);
        chk({tag, "_locked"}, int'(locked),      0);
        chk({tag, "_cerr"},   int'(code_err),    0);
        chk({tag, "_serr"},   int'(step_err),    0);
        chk({tag, "_errs"},   int'(err_count),   0);
    endtask

    logic [SZ-1:0] seq10 [10];
    logic [SZ-1:0] bad_codes [4];

    initial begin
        seq10 = '{4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1110,
                  4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        bad_codes = '{4'b1010, 4'b0101, 4'b1001, 4'b0110};
        in_valid = 1'b0;
        in_code  = '0;
        reset    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;

        // Full cycle with wrap 7->0; lock after the 4th sample.
        for (int i = 0; i < 10; i++) begin
            send(1'b1, seq10[i]);
            if (i == 0) chk("first_phase", int'(phase), 7);
            if (i == 2) chk("pre_lock", int'(locked), 0);
            if (i == 3) chk("lock_4th", int'(locked), 1);
        end
        chk("seq_end_phase", int'(phase), 0);
        chk("seq_end_errs",  int'(err_count), 0);

        // Illegal word while locked.
        send(1'b1, 4'b1010);
        chk("cerr_pulse",  int'(code_err), 1);
        chk("cerr_unlock", int'(locked), 0);
        chk("cerr_pv",     int'(phase_valid), 0);
        chk("cerr_phase",  int'(phase), 0);
        chk("cerr_count",  int'(err_count), 1);
        send(1'b0, 4'b0000);
        chk("cerr_one_cycle", int'(code_err), 0);

        // Relock to phase 2, then skip to phase 5.
        send(1'b1, 4'b0011); send(1'b1, 4'b0001); send(1'b1, 4'b0000);
        send(1'b1, 4'b1000); send(1'b1, 4'b1100);
        chk("relock_ph2", int'(locked), 1);
        send(1'b1, 4'b0111);
        chk("serr_pulse",  int'(step_err), 1);
        chk("serr_unlock", int'(locked), 0);
        chk("serr_phase",  int'(phase), 5);
        chk("serr_count",  int'(err_count), 2);
        send(1'b1, 4'b0011); send(1'b1, 4'b0001); send(1'b1, 4'b0000);
        chk("relock_after_serr", int'(locked), 1);

        // Idle cycles with junk on the bus must change nothing.
        for (int i = 0; i < 5; i++) send(1'b0, 4'(i * 5 + 3));
        chk("idle_phase",  int'(phase), 0);
        chk("idle_locked", int'(locked), 1);
        send(1'b1, 4'b1000);
        chk("resume_locked", int'(locked), 1);
        chk("resume_phase",  int'(phase), 1);

        // Repeated identical word is a step error.
        send(1'b1, 4'b1000);
        chk("repeat_serr",  int'(step_err), 1);
        chk("repeat_count", int'(err_count), 3);

        // Long illegal burst saturates the error counter.
        for (int i = 0; i < 300; i++) send(1'b1, bad_codes[i % 4]);
        chk("sat_count", int'(err_count), 255);
        chk("sat_cerr",  int'(code_err), 1);
        chk("sat_serr",  int'(step_err), 0);

        // Relock, then asynchronous reset between edges.
        send(1'b1, 4'b0000); send(1'b1, 4'b1000); send(1'b1, 4'b1100); send(1'b1, 4'b1110);
        chk("pre_rst_locked", int'(locked), 1);
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #1 reset = 1'b1;
        send(1'b1, 4'b0001); send(1'b1, 4'b0000); send(1'b1, 4'b1000);
        chk("post_rst_pre", int'(locked), 0);
        send(1'b1, 4'b1100);
        chk("post_rst_lock", int'(locked), 1);
        chk("post_rst_phase", int'(phase), 2);
        send(1'b0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
